// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ctrl_pkg : opcodes, FSM state codes and datapath select encodings
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

    localparam logic [5:0] OPC_SUBM = 6'b100011;
    localparam logic [5:0] OPC_ADDM = 6'b100010;
    localparam logic [5:0] OPC_SUBR = 6'b000001;
    localparam logic [5:0] OPC_LDAI = 6'b010010;
    localparam logic [5:0] OPC_INC  = 6'b010111;
    localparam logic [5:0] OPC_STA  = 6'b100100;
    localparam logic [5:0] OPC_JMP  = 6'b110000;
    localparam logic [5:0] OPC_JZ   = 6'b110001;
    localparam logic [5:0] OPC_JN   = 6'b110010;
    localparam logic [5:0] OPC_HLT  = 6'b111111;

    localparam logic [4:0] ST_F0   = 5'd0;
    localparam logic [4:0] ST_F1   = 5'd1;
    localparam logic [4:0] ST_DEC  = 5'd2;
    localparam logic [4:0] ST_M0   = 5'd3;
    localparam logic [4:0] ST_M1   = 5'd4;
    localparam logic [4:0] ST_I0   = 5'd5;
    localparam logic [4:0] ST_I1   = 5'd6;
    localparam logic [4:0] ST_R0   = 5'd7;
    localparam logic [4:0] ST_EX   = 5'd8;
    localparam logic [4:0] ST_X0   = 5'd9;
    localparam logic [4:0] ST_S1   = 5'd10;
    localparam logic [4:0] ST_B0   = 5'd11;
    localparam logic [4:0] ST_HALT = 5'd12;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_PASS = 4'd2;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_IR   = 3'd1;
    localparam logic [2:0] BUS_DR   = 3'd2;
    localparam logic [2:0] BUS_PC   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_REG  = 3'd5;

    // States that hold a memory access open until mem_ready
    function automatic logic is_wait_state(input logic [4:0] st);
        return (st == ST_F1) || (st == ST_M1) || (st == ST_I1) || (st == ST_S1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// ctrl_wait_timer : saturating memory-wait counter with timeout detect
// Revision : 1.0
// ============================================================================
module ctrl_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic waiting,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (start || (waiting && ready)) begin
            count_d = '0;
        end else if (waiting && (count_q != CNT_W'(WAIT_MAX))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires in the cycle the count would reach WAIT_MAX; a same-cycle ready wins
    generate
        if (WAIT_MAX > 0) begin : g_timeout
            assign expired = waiting && !ready && (count_q == CNT_W'(WAIT_MAX - 1));
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_control_unit.sv
`default_nettype none
// ============================================================================
// seq_control_unit : multi-cycle control FSM for the accumulator CPU
// Revision : 1.0
// ============================================================================
module seq_control_unit
    import ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int OPC_W     = 6,
    parameter int REG_SEL_W = 4,
    parameter int WAIT_MAX  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    ir_value,
    input  logic [3:0]           flags,
    input  logic                 mem_ready,
    output logic                 ir_load,
    output logic                 dr_load,
    output logic                 ar_load,
    output logic                 ac_load,
    output logic                 pc_load,
    output logic                 flags_load,
    output logic                 ac_inc,
    output logic                 pc_inc,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [3:0]           alu_sel,
    output logic [2:0]           bus_sel,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 halted,
    output logic                 illegal_op,
    output logic                 bus_err
);

    logic [4:0]       state_q, state_d;
    logic             illegal_op_q, illegal_op_d;
    logic             bus_err_q, bus_err_d;
    logic [OPC_W-1:0] opcode;
    logic             waiting, wait_start, expired, taken;
    logic             unused_bits;

    assign opcode      = ir_value[DATA_W-1 -: OPC_W];
    assign waiting     = is_wait_state(state_q);
    assign wait_start  = is_wait_state(state_d) && !waiting;
    assign taken       = (opcode == OPC_W'(OPC_JMP)) ||
                         ((opcode == OPC_W'(OPC_JZ)) && flags[0]) ||
                         ((opcode == OPC_W'(OPC_JN)) && flags[1]);
    assign illegal_op  = illegal_op_q;
    assign bus_err     = bus_err_q;
    assign unused_bits = ^{flags[3:2], ir_value};

    ctrl_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (wait_start),
        .waiting (waiting),
        .ready   (mem_ready),
        .expired (expired)
    );

    // Strobes are gated by rst so they drop the instant reset asserts
    always_comb begin
        state_d      = state_q;
        illegal_op_d = illegal_op_q;
        bus_err_d    = bus_err_q;
        ir_load = 1'b0; dr_load = 1'b0; ar_load    = 1'b0; ac_load = 1'b0;
        pc_load = 1'b0; ac_inc  = 1'b0; flags_load = 1'b0; pc_inc  = 1'b0;
        mem_req = 1'b0; mem_we  = 1'b0; halted     = 1'b0;
        alu_sel = ALU_ADD;
        bus_sel = BUS_NONE;
        reg_sel = '0;
        if (rst) begin
            case (state_q)
                ST_F0: begin
                    bus_sel = BUS_PC; ar_load = 1'b1; state_d = ST_F1;
                end
                ST_F1: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1; pc_inc = 1'b1; state_d = ST_DEC;
                    end else if (expired) begin
                        state_d = ST_HALT; bus_err_d = 1'b1;
                    end
                end
                ST_DEC: begin
                    case (opcode)
                        OPC_W'(OPC_ADDM), OPC_W'(OPC_SUBM),
                        OPC_W'(OPC_STA):  state_d = ST_M0;
                        OPC_W'(OPC_LDAI): state_d = ST_I0;
                        OPC_W'(OPC_SUBR): state_d = ST_R0;
                        OPC_W'(OPC_INC):  state_d = ST_X0;
                        OPC_W'(OPC_JMP), OPC_W'(OPC_JZ),
                        OPC_W'(OPC_JN):   state_d = ST_B0;
                        OPC_W'(OPC_HLT):  state_d = ST_HALT;
                        default: begin
                            state_d = ST_HALT; illegal_op_d = 1'b1;
                        end
                    endcase
                end
                ST_M0: begin
                    bus_sel = BUS_IR; ar_load = 1'b1;
                    state_d = (opcode == OPC_W'(OPC_STA)) ? ST_S1 : ST_M1;
                end
                ST_M1: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        dr_load = 1'b1; state_d = ST_EX;
                    end else if (expired) begin
                        state_d = ST_HALT; bus_err_d = 1'b1;
                    end
                end
                ST_I0: begin
                    bus_sel = BUS_PC; ar_load = 1'b1; state_d = ST_I1;
                end
                ST_I1: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        dr_load = 1'b1; pc_inc = 1'b1; state_d = ST_EX;
                    end else if (expired) begin
                        state_d = ST_HALT; bus_err_d = 1'b1;
                    end
                end
                ST_R0: begin
                    bus_sel = BUS_REG; reg_sel = ir_value[REG_SEL_W-1:0];
                    dr_load = 1'b1; state_d = ST_EX;
                end
                ST_EX: begin
                    ac_load = 1'b1; flags_load = 1'b1; state_d = ST_F0;
                    case (opcode)
                        OPC_W'(OPC_SUBM), OPC_W'(OPC_SUBR): alu_sel = ALU_SUB;
                        OPC_W'(OPC_LDAI):                  alu_sel = ALU_PASS;
                        default:                           alu_sel = ALU_ADD;
                    endcase
                end
                ST_X0: begin
                    ac_inc = 1'b1; flags_load = 1'b1; state_d = ST_F0;
                end
                ST_S1: begin
                    bus_sel = BUS_AC; mem_req = 1'b1; mem_we = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_F0;
                    end else if (expired) begin
                        state_d = ST_HALT; bus_err_d = 1'b1;
                    end
                end
                ST_B0: begin
                    if (taken) begin
                        bus_sel = BUS_IR; pc_load = 1'b1;
                    end
                    state_d = ST_F0;
                end
                ST_HALT: halted = 1'b1;
                default: state_d = ST_F0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_F0;
            illegal_op_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
            bus_err_q    <= bus_err_d;
        end
    end

endmodule
`default_nettype wire
